// File: rtl/cy10lp_pio_pkg.sv
// Shared constants for the Qsys PIO peripherals: register word addresses
// and edge-capture sense selectors.
package cy10lp_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_RSVD    = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/cy10lp_pio_in_sync.sv
// Two-flop synchronizer for the external input bus, followed by a one-cycle
// history register and a per-bit edge detector of elaboration-time sense.
module cy10lp_pio_in_sync
  import cy10lp_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_TYPE  = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] sync_data,
  output logic [DATA_WIDTH-1:0] edge_det
);

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync2;
  logic [DATA_WIDTH-1:0] r_prev;

  // NOTE: non-blocking assignments make the three stages shift in lockstep;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign sync_data = r_sync2;

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign edge_det = ~r_sync2 & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_det = r_sync2 ^ r_prev;
    end else begin : g_rising
      assign edge_det = r_sync2 & ~r_prev;
    end
  endgenerate

endmodule

// File: rtl/cy10lp_qsys_pio_in.sv
// Avalon-MM input PIO: synchronized data register, sticky W1C edge capture,
// interrupt mask and a level interrupt for unmasked captured edges.
module cy10lp_qsys_pio_in
  import cy10lp_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    EDGE_TYPE      = EDGE_RISING,
  parameter logic [DATA_WIDTH-1:0] IRQ_MASK_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_sync_data;
  logic [DATA_WIDTH-1:0] w_edge_det;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_clr;
  logic                  w_unused_wdata;
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_edge_capture;

  cy10lp_pio_in_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .sync_data (w_sync_data),
    .edge_det  (w_edge_det)
  );

  assign w_wr_en        = chipselect & ~write_n;
  assign w_clr          = (w_wr_en && address == PIO_ADDR_EDGECAP) ?
                          writedata[DATA_WIDTH-1:0] : '0;
  assign w_unused_wdata = ^writedata;

  // A fresh edge is OR-ed in after the clear, so it wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask     <= IRQ_MASK_RESET;
      r_edge_capture <= '0;
    end else begin
      if (w_wr_en && address == PIO_ADDR_IRQMASK) begin
        r_irq_mask <= writedata[DATA_WIDTH-1:0];
      end
      r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge_det;
    end
  end

  // NOTE: readdata gets its default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    readdata = '0;
    case (pio_addr_e'(address))
      PIO_ADDR_DATA:    readdata[DATA_WIDTH-1:0] = w_sync_data;
      PIO_ADDR_IRQMASK: readdata[DATA_WIDTH-1:0] = r_irq_mask;
      PIO_ADDR_EDGECAP: readdata[DATA_WIDTH-1:0] = r_edge_capture;
      default:          readdata = '0;
    endcase
  end

  assign irq = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_cy10lp_qsys_pio_in.sv
// Bench for the input PIO: three instances (rising/8, falling/4, any/8) on a
// shared bus, directed vectors, hand sequences and a randomized model check.
module tb_cy10lp_qsys_pio_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in0 = 8'h00;
  logic [3:0]  in1 = 4'hF;
  logic [7:0]  in2 = 8'h00;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cy10lp_qsys_pio_in #(.DATA_WIDTH(8), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  cy10lp_qsys_pio_in #(.DATA_WIDTH(4), .EDGE_TYPE(1)) u_dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  cy10lp_qsys_pio_in #(.DATA_WIDTH(8), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  // Reference model: each instance remembers its last three sampled inputs;
  // the value two samples old is what software sees, and an edge is judged
  // between the samples two and three edges old.
  logic [31:0] m_hist [3][3];
  logic [31:0] m_cap  [3];
  logic [31:0] m_mask [3];

  function automatic logic [31:0] wmask(input int i);
    return (i == 1) ? 32'h0000_000F : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] in_of(input int i);
    case (i)
      0:       return {24'h0, in0};
      1:       return {28'h0, in1};
      default: return {24'h0, in2};
    endcase
  endfunction

  function automatic logic [31:0] det_of(input int i);
    logic [31:0] now_v, old_v;
    now_v = m_hist[i][1];
    old_v = m_hist[i][2];
    case (i)
      0:       return now_v & ~old_v;
      1:       return ~now_v & old_v & wmask(i);
      default: return now_v ^ old_v;
    endcase
  endfunction

  function automatic bit bus_wr(input logic [1:0] a);
    return chipselect && !write_n && address == a;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) m_hist[i][j] <= '0;
        m_cap[i]  <= '0;
        m_mask[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_cap[i] <= (m_cap[i] & ~(bus_wr(2'd3) ? writedata & wmask(i) : 32'h0))
                    | det_of(i);
        if (bus_wr(2'd2)) m_mask[i] <= writedata & wmask(i);
        m_hist[i][0] <= in_of(i);
        m_hist[i][1] <= m_hist[i][0];
        m_hist[i][2] <= m_hist[i][1];
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int i, input logic [1:0] a);
    case (a)
      2'd0:    return m_hist[i][1];
      2'd2:    return m_mask[i];
      2'd3:    return m_cap[i];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_of(input int i);
    case (i)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic irq_of(input int i);
    case (i)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input int inst, input logic [1:0] a, input logic [31:0] exp,
                        input string name);
    address = a;
    #1;
    check(name, rd_of(inst), exp);
  endtask

  task automatic chk_irq(input int inst, input logic exp, input string name);
    check(name, {31'h0, irq_of(inst)}, {31'h0, exp});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  in_v;
    bit          wr_en;
    logic [1:0]  wr_a;
    logic [31:0] wr_d;
    logic [7:0]  e_data;
    logic [7:0]  e_mask;
    logic [7:0]  e_cap;
    bit          e_irq;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{"mask01",  8'hA5, 1, 2'd2, 32'h0000_0001, 8'hA5, 8'h01, 8'hA5, 1};
    vecs[1]  = '{"w1c01",   8'hA5, 1, 2'd3, 32'h0000_0001, 8'hA5, 8'h01, 8'hA4, 0};
    vecs[2]  = '{"fall0",   8'hA4, 0, 2'd0, 32'h0000_0000, 8'hA4, 8'h01, 8'hA4, 0};
    vecs[3]  = '{"w1c05",   8'hA4, 1, 2'd3, 32'h0000_0005, 8'hA4, 8'h01, 8'hA0, 0};
    vecs[4]  = '{"w1c00",   8'hA4, 1, 2'd3, 32'h0000_0000, 8'hA4, 8'h01, 8'hA0, 0};
    vecs[5]  = '{"wr_data", 8'hA4, 1, 2'd0, 32'h0000_00FF, 8'hA4, 8'h01, 8'hA0, 0};
    vecs[6]  = '{"wr_rsvd", 8'hA4, 1, 2'd1, 32'h0000_00FF, 8'hA4, 8'h01, 8'hA0, 0};
    vecs[7]  = '{"mask_hi", 8'hFF, 1, 2'd2, 32'hDEAD_BE7F, 8'hFF, 8'h7F, 8'hFB, 1};
    vecs[8]  = '{"w1c_all", 8'hFF, 1, 2'd3, 32'h0000_00FF, 8'hFF, 8'h7F, 8'h00, 0};
    vecs[9]  = '{"fall7",   8'h7F, 0, 2'd0, 32'h0000_0000, 8'h7F, 8'h7F, 8'h00, 0};
    vecs[10] = '{"gated7",  8'hFF, 0, 2'd0, 32'h0000_0000, 8'hFF, 8'h7F, 8'h80, 0};
    vecs[11] = '{"maskFF",  8'hFF, 1, 2'd2, 32'h0000_00FF, 8'hFF, 8'hFF, 8'h80, 1};

    // Reset state
    repeat (3) cycle();
    chk_irq(0, 1'b0, "rst_irq0");
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) chk_rd(0, 2'(a), 32'h0, $sformatf("rst_rd%0d", a));
    chk_irq(0, 1'b0, "rst_irq_rise");
    chk_irq(1, 1'b0, "rst_irq_fall");
    chk_irq(2, 1'b0, "rst_irq_any");

    // Data latency: visible two clocks after the change, captured one later
    in0 = 8'hA5;
    cycle();
    chk_rd(0, 2'd0, 32'h0000_0000, "lat_k");
    cycle();
    chk_rd(0, 2'd0, 32'h0000_00A5, "lat_k1");
    chk_rd(0, 2'd3, 32'h0000_0000, "cap_k1");
    cycle();
    chk_rd(0, 2'd3, 32'h0000_00A5, "cap_k2");
    chk_irq(0, 1'b0, "cap_k2_irq");

    for (int v = 0; v < 12; v++) begin
      in0 = vecs[v].in_v;
      if (vecs[v].wr_en) wr(vecs[v].wr_a, vecs[v].wr_d);
      else cycle();
      cycle();
      cycle();
      chk_rd(0, 2'd0, {24'h0, vecs[v].e_data}, {vecs[v].name, ".data"});
      chk_rd(0, 2'd1, 32'h0,                   {vecs[v].name, ".rsvd"});
      chk_rd(0, 2'd2, {24'h0, vecs[v].e_mask}, {vecs[v].name, ".mask"});
      chk_rd(0, 2'd3, {24'h0, vecs[v].e_cap},  {vecs[v].name, ".cap"});
      chk_irq(0, vecs[v].e_irq,                {vecs[v].name, ".irq"});
    end

    // Asynchronous reset mid-cycle, with the input held high through it
    #2;
    reset_n = 1'b0;
    #1;
    chk_irq(0, 1'b0, "arst_irq");
    chk_rd(0, 2'd3, 32'h0, "arst_cap");
    chk_rd(0, 2'd2, 32'h0, "arst_mask");
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();
    chk_rd(0, 2'd0, 32'h0000_00FF, "post_rst_data");
    chk_rd(0, 2'd3, 32'h0000_0000, "post_rst_cap_early");
    cycle();
    chk_rd(0, 2'd3, 32'h0000_00FF, "post_rst_rise");
    chk_irq(0, 1'b0, "post_rst_irq");

    // Falling sense, 4-bit instance
    in1 = 4'hB;
    repeat (3) cycle();
    chk_rd(1, 2'd0, 32'h0000_000B, "fall_data");
    chk_rd(1, 2'd3, 32'h0000_0004, "fall_cap");
    chk_irq(1, 1'b0, "fall_irq_masked");
    wr(2'd2, 32'hABCD_EF05);
    chk_rd(1, 2'd2, 32'h0000_0005, "fall_mask_w4");
    chk_irq(1, 1'b1, "fall_irq");

    // Any-edge: second edge coincides with a clear of the same bit
    wr(2'd2, 32'h0000_00FF);
    in2 = 8'h08;
    repeat (3) cycle();
    chk_rd(2, 2'd3, 32'h0000_0008, "any_rise");
    chk_irq(2, 1'b1, "any_rise_irq");
    wr(2'd3, 32'h0000_0008);
    chk_rd(2, 2'd3, 32'h0000_0000, "any_clr");
    chk_irq(2, 1'b0, "any_clr_irq");
    in2 = 8'h00;
    cycle();
    cycle();
    wr(2'd3, 32'h0000_0008);
    chk_rd(2, 2'd3, 32'h0000_0008, "any_edge_wins");
    chk_irq(2, 1'b1, "any_edge_wins_irq");

    // Randomized traffic against the reference model
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      in0        = 8'($urandom);
      in1        = 4'($urandom);
      in2        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : in2;
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      cycle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'($urandom_range(0, 3));
      #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rnd%0d.rd%0d.i%0d", n, address, i), rd_of(i), exp_rd(i, address));
        check($sformatf("rnd%0d.irq.i%0d", n, i), {31'h0, irq_of(i)},
              {31'h0, |(m_cap[i] & m_mask[i])});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
